// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with handshaked imem/dmem ports, halt control and a retired-instruction counter
module hack_cpu_mc #(
  parameter int W = 16,
  parameter int AW = 15,
  parameter int CW = 32
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          halt,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_re,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [W-1:0]  dmem_wdata,
  input  logic          dmem_ready,
  input  logic [W-1:0]  dmem_rdata,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [CW-1:0] instret
);
  typedef enum logic [2:0] {FETCH, LOAD, EXEC, STORE, HALT} cpuState;
  cpuState state, stateNext;
  logic [W-1:0] regA, regD, md, x0, x1, y0, y1, sum, aluOut;
  logic [AW-1:0] pcReg, pcNext;
  logic [15:0] ir;
  logic [CW-1:0] retCount;
  logic isC, toMem, jump, retire;
  assign isC = ir[15];
  assign toMem = isC & ir[3];
  always_comb begin
    x0 = ir[11] ? '0 : regD;
    x1 = ir[10] ? ~x0 : x0;
    y0 = ir[9] ? '0 : (ir[12] ? md : regA);
    y1 = ir[8] ? ~y0 : y0;
    sum = ir[7] ? x1 + y1 : x1 & y1;
    aluOut = ir[6] ? ~sum : sum;
    jump = isC && ((ir[2] && aluOut[W-1]) || (ir[1] && aluOut == '0) || (ir[0] && !aluOut[W-1] && aluOut != '0));
    pcNext = jump ? regA[AW-1:0] : pcReg + AW'(1);
  end
  always_ff @(posedge CLK) state <= reset ? FETCH : stateNext;
  always_comb begin
    stateNext = state;
    case (state)
      FETCH: if (imem_ready) stateNext = (imem_rdata[15] && imem_rdata[12]) ? LOAD : EXEC;
      LOAD: if (dmem_ready) stateNext = EXEC;
      EXEC: stateNext = toMem ? STORE : (halt ? HALT : FETCH);
      STORE: if (dmem_ready) stateNext = halt ? HALT : FETCH;
      HALT: if (!halt) stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
  end
  always_comb begin
    imem_req = !reset && state == FETCH;
    dmem_re = !reset && state == LOAD;
    dmem_we = !reset && state == STORE;
    halted = !reset && state == HALT;
    retire = !reset && ((state == EXEC && !toMem) || (state == STORE && dmem_ready));
  end
  assign imem_addr = pcReg;
  assign dmem_addr = regA[AW-1:0];
  assign dmem_wdata = aluOut;
  assign pc = pcReg;
  assign instret = retCount;
  always_ff @(posedge CLK) begin
    if (reset) begin
      regA <= '0;
      regD <= '0;
      md <= '0;
      ir <= '0;
      pcReg <= '0;
      retCount <= '0;
    end else begin
      if (imem_req && imem_ready) ir <= imem_rdata;
      if (dmem_re && dmem_ready) md <= dmem_rdata;
      if (retire) begin
        if (!isC) regA <= W'(ir[14:0]);
        else if (ir[5]) regA <= aluOut;
        if (isC && ir[4]) regD <= aluOut;
        pcReg <= pcNext;
        retCount <= retCount + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc: directed scoreboard bench for hack_cpu_mc with a wait-state memory model
module tb_hack_cpu_mc;
  localparam int W = 24;
  localparam int AW = 4;
  localparam int CW = 32;
  logic CLK = 0, reset = 1, halt = 0, imem_ready = 0, dmem_ready = 0;
  logic [15:0] imem_rdata = '0;
  logic [W-1:0] dmem_rdata = '0;
  logic imem_req, dmem_re, dmem_we, halted;
  logic [AW-1:0] imem_addr, dmem_addr, pc;
  logic [W-1:0] dmem_wdata;
  logic [CW-1:0] instret;
  logic [15:0] rom [16];
  logic [W-1:0] ram [16];
  int iDelay = 0, dDelay = 0, iCnt = 0, dCnt = 0;
  logic pendI = 0, pendD = 0, lastRe = 0, lastWe = 0;
  logic [AW-1:0] lastIAddr = '0, lastDAddr = '0;
  logic [W-1:0] lastWData = '0;
  typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} stT;
  stT stQ[$];
  stT e;
  logic [AW-1:0] pcQ[$];
  int vectors = 0, errs = 0, cyc = 0;
  always #5 CLK = ~CLK;
  hack_cpu_mc #(.W(W), .AW(AW), .CW(CW)) dut (
    .CLK(CLK), .reset(reset), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .instret(instret)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic doReset(input int n);
    reset = 1;
    halt = 0;
    repeat (n) tick();
    reset = 0;
    #1;
  endtask
  task automatic waitRet(input logic [CW-1:0] target, input int budget, output int c);
    c = 0;
    while (instret !== target && c < budget) begin
      tick();
      c++;
    end
    check("retire reached", instret, target);
  endtask
  always @(negedge CLK) begin
    check("exclusive requests", 64'($countones({imem_req, dmem_re, dmem_we}) <= 1), 64'd1);
    if (pendI && !reset) check("imem hold", {imem_req, imem_addr}, {1'b1, lastIAddr});
    if (pendD && !reset)
      check("dmem hold", {dmem_re, dmem_we, dmem_addr, lastWe ? dmem_wdata : W'(0)},
                         {lastRe, lastWe, lastDAddr, lastWe ? lastWData : W'(0)});
    if (!reset && imem_req) begin
      imem_ready = iCnt >= iDelay;
      if (imem_ready) begin
        imem_rdata = rom[imem_addr];
        iCnt = 0;
      end else iCnt++;
    end else begin
      imem_ready = 0;
      iCnt = 0;
    end
    if (!reset && (dmem_re || dmem_we)) begin
      dmem_ready = dCnt >= dDelay;
      if (dmem_ready) begin
        dCnt = 0;
        if (dmem_re) dmem_rdata = ram[dmem_addr];
        if (dmem_we) begin
          ram[dmem_addr] = dmem_wdata;
          check("store expected", 64'(stQ.size() != 0), 64'd1);
          if (stQ.size() != 0) begin
            e = stQ.pop_front();
            check("store addr/data", {dmem_addr, dmem_wdata}, {e.a, e.d});
          end
        end
      end else dCnt++;
    end else begin
      dmem_ready = 0;
      dCnt = 0;
    end
    pendI = !reset && imem_req && !imem_ready;
    lastIAddr = imem_addr;
    pendD = !reset && (dmem_re || dmem_we) && !dmem_ready;
    lastRe = dmem_re;
    lastWe = dmem_we;
    lastDAddr = dmem_addr;
    lastWData = dmem_wdata;
  end
  initial begin
    rom = '{0:16'h0005, 1:16'hEC10, 2:16'h0007, 3:16'hE090, 4:16'h0000, 5:16'hE308,
            6:16'h0006, 7:16'hEA87, default:16'h0000};
    ram = '{default:'0};
    repeat (3) tick();
    check("reset imem_req", imem_req, 0);
    check("reset dmem_re/we", {dmem_re, dmem_we}, 0);
    check("reset halted", halted, 0);
    check("reset pc", pc, 0);
    check("reset instret", instret, 0);
    check("reset dmem_addr/wdata", {dmem_addr, dmem_wdata}, 0);
    reset = 0;
    #1;
    check("first fetch", {imem_req, imem_addr, dmem_re, dmem_we}, {1'b1, 4'd0, 2'b00});
    stQ.push_back('{a:4'd0, d:24'd12});
    waitRet(6, 100, cyc);
    check("zero-wait cycles", cyc, 13);
    check("D after program", dut.regD, 24'd12);
    check("A after program", dut.regA, 24'd0);
    check("pc after program", pc, 6);
    check("RAM[0]", ram[0], 24'd12);
    halt = 1;
    for (int i = 0; i < 10 && halted !== 1'b1; i++) tick();
    check("halted at boundary", halted, 1);
    check("instret at halt", instret, 7);
    ram[0] = '0;
    iDelay = 2;
    dDelay = 2;
    stQ.push_back('{a:4'd0, d:24'd12});
    doReset(1);
    waitRet(6, 200, cyc);
    check("wait-state cycles", cyc, 27);
    check("D after slow program", dut.regD, 24'd12);
    check("A after slow program", dut.regA, 24'd0);
    check("pc after slow program", pc, 6);
    check("RAM[0] slow", ram[0], 24'd12);
    iDelay = 0;
    dDelay = 0;
    rom = '{0:16'h0002, 1:16'hEA87, 2:16'h0003, 3:16'hEA87, default:16'h0000};
    pcQ = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    doReset(1);
    for (int k = 1; k <= 5; k++) begin
      waitRet(k, 20, cyc);
      check("loop pc", pc, pcQ.pop_front());
    end
    rom = '{0:16'h7FFF, 1:16'hFDC8, 2:16'hEE90, 3:16'h0009, 4:16'hE304,
            9:16'hE301, 10:16'h000A, 11:16'hEA87, default:16'h0000};
    ram[15] = 24'hFFFFFF;
    stQ.push_back('{a:4'd15, d:24'd0});
    pcQ = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11};
    doReset(1);
    waitRet(1, 20, cyc);
    check("A wide value", dut.regA, 24'h007FFF);
    check("dmem_addr low bits", dmem_addr, 4'hF);
    check("pc step 1", pc, pcQ.pop_front());
    waitRet(2, 20, cyc);
    check("M=M+1 cycles", cyc, 4);
    check("RAM[15] wrapped", ram[15], 24'd0);
    check("pc step 2", pc, pcQ.pop_front());
    waitRet(3, 20, cyc);
    check("D=-1", dut.regD, 24'hFFFFFF);
    check("pc step 3", pc, pcQ.pop_front());
    for (int k = 4; k <= 7; k++) begin
      waitRet(k, 20, cyc);
      check("jump pc", pc, pcQ.pop_front());
    end
    rom = '{0:16'h0005, 1:16'hFC10, 2:16'h0002, 3:16'hEA87, default:16'h0000};
    ram[5] = 24'd42;
    dDelay = 3;
    doReset(1);
    for (int i = 0; i < 20 && dmem_re !== 1'b1; i++) tick();
    check("load seen", dmem_re, 1);
    halt = 1;
    for (int i = 0; i < 30 && halted !== 1'b1; i++) tick();
    check("halted after load", halted, 1);
    check("instret after load", instret, 2);
    check("D loaded", dut.regD, 24'd42);
    check("pc at halt", pc, 2);
    repeat (3) begin
      tick();
      check("no requests while halted", {imem_req, dmem_re, dmem_we, halted}, 4'b0001);
    end
    halt = 0;
    tick();
    check("resume fetch", {imem_req, imem_addr, halted}, {1'b1, 4'd2, 1'b0});
    rom = '{0:16'h0003, 1:16'hEFF8, 2:16'h0002, 3:16'hEA87, default:16'h0000};
    ram[3] = '0;
    dDelay = 5;
    doReset(1);
    for (int i = 0; i < 20 && dmem_we !== 1'b1; i++) tick();
    check("store seen", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 4'd3, 24'd1});
    tick();
    reset = 1;
    #1;
    check("requests dropped in reset", {imem_req, dmem_re, dmem_we}, 3'b000);
    tick();
    reset = 0;
    #1;
    check("A after aborted store", dut.regA, 24'd0);
    check("D after aborted store", dut.regD, 24'd0);
    check("pc after aborted store", pc, 0);
    check("instret after aborted store", instret, 0);
    repeat (2) tick();
    check("RAM[3] untouched", ram[3], 24'd0);
    check("store queue drained", stQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Multi-cycle, parametrised Hack CPU core with handshaked instruction and data memory ports. It is the next generation of the single-cycle Hack CPU used in the computer top level. It runs the unchanged Hack instruction set over a configurable data width and address width, and tolerates memories with arbitrary wait states. It also adds run/halt control and a retired-instruction counter, and sits between the ROM and RAM/peripheral memory in the computer top level.

## Interface
Parameters:
- W, 16: data/register width, minimum 16.
- AW, 15: address width, 1..15. PC and memory addresses are AW bits.
- CW, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- halt  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address, equal to PC.
- imem_ready  in  1  fetch completes on the edge where req and ready are both high.
- imem_rdata  in  16  instruction word, valid with ready.
- dmem_re  out  1  data read request.
- dmem_we  out  1  data write request.
- dmem_addr  out  AW  equal to A[AW-1:0].
- dmem_wdata  out  W  ALU result.
- dmem_ready  in  1  data access completes on the edge where re or we, and ready, are both high.
- dmem_rdata  in  W  read data, valid with ready.
- pc  out  AW  current PC.
- halted  out  1  core is in HALT.
- instret  out  CW  retired-instruction count.

## Operation
- State registers: A (W), D (W), PC (AW), IR (16), MD (W, latched memory data), instret (CW), FSM state.
- FETCH: assert imem_req. On ready, latch IR.
  - Next state is LOAD if the word is a C-instruction (bit15=1) with bit12=1.
  - Otherwise next state is EXEC.
- LOAD: assert dmem_re with addr=A. On ready, latch MD and go to EXEC.
- EXEC, A-instruction: A <= zero-extended IR[14:0]. PC <= PC+1. Retire.
- EXEC, C-instruction:
  - ALU x=D; y = bit12 ? MD : A.
  - Control bits are zx=IR[11], nx=IR[10], zy=IR[9], ny=IR[8], f=IR[7] (1 selects add, 0 selects and), no=IR[6]. All operate W-bit, wrapping.
  - If dest M (IR[3]) is set, go to STORE without committing anything.
  - Otherwise commit: A if IR[5], D if IR[4], then PC, then retire.
- STORE: assert dmem_we with addr=old A and wdata=ALU result.
  - dmem_addr and dmem_wdata are held stable until ready.
  - On ready, commit A/D, PC, retire.
- Jump: ALU result is treated as signed W-bit.
  - Take the jump if (IR[2] and out<0), or (IR[1] and out==0), or (IR[0] and out>0).
  - Taken: PC <= old A[AW-1:0], the value before this instruction's A write. Not taken: PC <= PC+1.
- PC wraps mod 2^AW. A-instruction values above 2^AW-1 are kept whole in A; only the low AW bits drive addresses.
- Retire means instret <= instret+1, wrapping mod 2^CW. After retiring, go to HALT if halt=1, else FETCH.
- HALT: no requests are asserted and halted=1. Leave for FETCH on the first edge with halt=0.
- Request exclusivity: at most one of imem_req, dmem_re, dmem_we is high in any cycle.
- Request stability: a request stays high with constant address and data until accepted.

## Timing
- Reset: on any edge with reset=1, A=D=PC=IR=MD=instret=0, state=FETCH, halted=0.
  - All request outputs are 0 during the reset cycle.
  - The first imem_req appears the cycle after reset deasserts.
  - Reset mid-transaction aborts the access. The memory must accept a dropped request.
  - A STORE aborted by reset performs no register commit.
- Zero-wait latency, in cycles: A-instruction or C-instruction without M: 2. C with M read: 3. C with M write: 3. C with M read and write: 4.
- Each wait cycle on ready adds exactly one cycle.
- halt asserted mid-instruction takes effect only at retirement. halt never interrupts an instruction.

## Test plan
- Reset held for 3 cycles, then released: all outputs 0, imem_req=1 with imem_addr=0 on the first cycle after release.
- @5, D=A, @7, D=D+A, @0, M=D at zero wait:
  - RAM[0]=12.
  - instret=6 after 2+2+2+2+2+3=13 cycles.
- Same program with imem_ready and dmem_ready each delayed 2 cycles per access:
  - Identical final state.
  - Addresses and data held stable while waiting.
  - Never more than one request active.
- Loop @3, 0;JMP at address 2: PC alternates 2→3→3 as required. Then @32767 with AW=4: A=32767, dmem_addr=15.
- W=24: D=-1 then D;JLT taken, D;JGT not taken. M=M+1 on RAM[A]=0xFFFFFF yields 0 and takes 4 cycles.
- halt raised during a LOAD: the instruction completes, then halted=1 and no requests are made. Drop halt: the next fetch is at PC+1. Reset asserted during a STORE wait: no A/D change and PC=0.
